// File: rtl/hazard_unit_sb.sv
// ----------------------------------------------------------------------------
// hazard_unit_sb
//
// Purpose:
//   Hazard unit for a 5-stage pipeline with a multi-cycle (MUL/DIV) side unit.
//   It handles the following:
//     - M/W operand forwarding into the E stage (M has priority over W).
//     - Load-use detection with a programmable stall length of LOAD_STALL
//       bubbles.
//     - A register scoreboard that tracks outstanding multi-cycle results.
//       It raises RAW/WAW stalls in D, plus a structural stall while the
//       multi-cycle unit is busy.
//     - Branch redirect: flush of IF-ID and ID-EX, with the PC kept free to
//       take the redirect.
//
// Parameters:
//   REG_AW      register address width
//   NUM_REGS    number of architectural registers (2**REG_AW)
//   LOAD_STALL  bubbles inserted per load-use hazard (1..7)
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_rs1_d, i_rs2_d, i_rd_d  D-stage sources / destination
//   i_mc_op_d                 D-stage instruction is multi-cycle
//   i_rs1_e, i_rs2_e, i_rd_e  E-stage sources / destination
//   i_reg_write_e             E instruction writes rd
//   i_result_src_e0           E instruction is a load
//   i_mc_issue_e              E instruction issues to the multi-cycle unit
//   i_mc_busy                 multi-cycle unit cannot accept an op
//   i_mc_done, i_mc_rd_done   multi-cycle writeback this cycle and its rd
//   i_rd_m, i_rd_w            M/W destination registers
//   i_reg_write_m/_w          M/W write enables
//   i_pc_src_e                taken branch/jump resolved in E
//   o_forward_a_e/_b_e        2'b10 = M, 2'b01 = W, 2'b00 = regfile
//   o_stall_f, o_stall_d      hold PC / IF-ID register
//   o_flush_d, o_flush_e      clear IF-ID / ID-EX register
//   o_lw_stall                load-use stall active
//   o_mc_stall                scoreboard / structural stall active
//   o_pending                 scoreboard bitmap (debug)
// ----------------------------------------------------------------------------
module hazard_unit_sb #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned NUM_REGS   = 2**REG_AW,
   parameter int unsigned LOAD_STALL = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   // D stage
   input  logic [REG_AW-1:0]   i_rs1_d,
   input  logic [REG_AW-1:0]   i_rs2_d,
   input  logic [REG_AW-1:0]   i_rd_d,
   input  logic                i_mc_op_d,
   // E stage
   input  logic [REG_AW-1:0]   i_rs1_e,
   input  logic [REG_AW-1:0]   i_rs2_e,
   input  logic [REG_AW-1:0]   i_rd_e,
   input  logic                i_reg_write_e,
   input  logic                i_result_src_e0,
   input  logic                i_mc_issue_e,
   // multi-cycle unit
   input  logic                i_mc_busy,
   input  logic                i_mc_done,
   input  logic [REG_AW-1:0]   i_mc_rd_done,
   // M / W stages
   input  logic [REG_AW-1:0]   i_rd_m,
   input  logic [REG_AW-1:0]   i_rd_w,
   input  logic                i_reg_write_m,
   input  logic                i_reg_write_w,
   // branch resolution
   input  logic                i_pc_src_e,
   // outputs
   output logic [1:0]          o_forward_a_e,
   output logic [1:0]          o_forward_b_e,
   output logic                o_stall_f,
   output logic                o_stall_d,
   output logic                o_flush_d,
   output logic                o_flush_e,
   output logic                o_lw_stall,
   output logic                o_mc_stall,
   output logic [NUM_REGS-1:0] o_pending
);

   // First-cycle reload value. The detecting cycle itself is the first bubble.
   localparam logic [2:0] LCNT_INIT = 3'(LOAD_STALL - 1);

   logic [2:0]          r_lcnt;
   logic [2:0]          w_lcnt_d;
   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_pending_d;

   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_pend_eff;

   logic                w_lu_hit;
   logic                w_raw;
   logic                w_waw;
   logic                w_struct;
   logic                w_stall;

   // -------------------------------------------------------------------------
   // Forwarding. A match needs both the address and the write enable, and a
   // source of x0 never forwards.
   // -------------------------------------------------------------------------
   always_comb begin
      o_forward_a_e = 2'b00;
      if ((i_rs1_e != '0) && i_reg_write_m && (i_rd_m == i_rs1_e)) begin
         o_forward_a_e = 2'b10;
      end else if ((i_rs1_e != '0) && i_reg_write_w && (i_rd_w == i_rs1_e)) begin
         o_forward_a_e = 2'b01;
      end
   end

   always_comb begin
      o_forward_b_e = 2'b00;
      if ((i_rs2_e != '0) && i_reg_write_m && (i_rd_m == i_rs2_e)) begin
         o_forward_b_e = 2'b10;
      end else if ((i_rs2_e != '0) && i_reg_write_w && (i_rd_w == i_rs2_e)) begin
         o_forward_b_e = 2'b01;
      end
   end

   // -------------------------------------------------------------------------
   // Load-use detection and stall counter
   // -------------------------------------------------------------------------
   assign w_lu_hit = i_result_src_e0 & i_reg_write_e & (i_rd_e != '0) &
                     ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));

   // A redirect squashes the dependent instruction, so any remaining bubbles
   // are dropped.
   always_comb begin
      w_lcnt_d = r_lcnt;
      if (i_pc_src_e) begin
         w_lcnt_d = 3'd0;
      end else if (w_lu_hit && (r_lcnt == 3'd0)) begin
         w_lcnt_d = LCNT_INIT;
      end else if (r_lcnt != 3'd0) begin
         w_lcnt_d = r_lcnt - 3'd1;
      end
   end

   assign o_lw_stall = w_lu_hit | (r_lcnt != 3'd0);

   // -------------------------------------------------------------------------
   // Scoreboard. Bit 0 is never decoded, which keeps x0 permanently clear.
   // -------------------------------------------------------------------------
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         w_set_mask[k] = i_mc_issue_e & (i_rd_e == REG_AW'(k));
         w_clr_mask[k] = i_mc_done & (i_mc_rd_done == REG_AW'(k));
      end
   end

   // Set is applied after clear, so a same-cycle set/clear on one reg sets.
   always_comb begin
      w_pending_d    = (r_pending & ~w_clr_mask) | w_set_mask;
      w_pending_d[0] = 1'b0;
   end

   // A writeback this cycle already resolves its register, which avoids an
   // extra bubble.
   assign w_pend_eff = r_pending & ~w_clr_mask;

   assign w_raw    = w_pend_eff[i_rs1_d] | w_pend_eff[i_rs2_d];
   assign w_waw    = (i_rd_d != '0) & w_pend_eff[i_rd_d];
   assign w_struct = i_mc_op_d & i_mc_busy;

   assign o_mc_stall = w_raw | w_waw | w_struct;
   assign o_pending  = r_pending;

   // -------------------------------------------------------------------------
   // Stall / flush combination. The PC must not be held while a redirect is
   // resolving.
   // -------------------------------------------------------------------------
   assign w_stall   = o_lw_stall | o_mc_stall;
   assign o_stall_f = w_stall & ~i_pc_src_e;
   assign o_stall_d = w_stall & ~i_pc_src_e;
   assign o_flush_d = i_pc_src_e;
   assign o_flush_e = w_stall | i_pc_src_e;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_lcnt    <= 3'd0;
         r_pending <= '0;
      end else begin
         r_lcnt    <= w_lcnt_d;
         r_pending <= w_pending_d;
      end
   end

endmodule
